// File: rtl/bp_me_cce_mock_mem_if.sv
// CCE <-> memory command/response channel. Signal names are from the memory
// side: _i is driven by the CCE (master), _o by the memory (slave).
interface bp_me_cce_mock_mem_if #(parameter int msg_width_p = 566);
  logic [msg_width_p-1:0] mem_cmd_i;
  logic                   mem_cmd_v_i;
  logic                   mem_cmd_ready_o;
  logic [msg_width_p-1:0] mem_resp_o;
  logic                   mem_resp_v_o;
  logic                   mem_resp_yumi_i;

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
  );
endinterface

// File: rtl/bp_me_cce_mock_mem.sv
// Single-outstanding mock memory for the CCE: applies each command to a
// zero-initialised block store and returns one response after latency_p cycles.
module bp_me_cce_mock_mem
  #(parameter int paddr_width_p     = 40
   ,parameter int cce_block_width_p = 512
   ,parameter int lce_id_width_p    = 4
   ,parameter int lce_assoc_p       = 8
   ,parameter int mem_els_p         = 1024
   ,parameter int latency_p         = 4
   )
  (input  logic                      clk_i
  ,input  logic                      reset_i
  ,bp_me_cce_mock_mem_if.slave       mem_io
  );

  localparam int block_bytes_lp = cce_block_width_p / 8;
  localparam int off_w_lp       = $clog2(block_bytes_lp);
  localparam int nb_w_lp        = off_w_lp + 1;
  localparam int idx_w_lp       = $clog2(mem_els_p);
  localparam int payload_w_lp   = lce_id_width_p + $clog2(lce_assoc_p);

  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_wr    = 4'd1;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

  typedef struct packed {
    logic [payload_w_lp-1:0]  payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               msg_type;
  } hdr_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    hdr_s                         hdr;
  } msg_s;

  typedef enum logic [1:0] {e_reset, e_ready, e_wait, e_resp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  msg_s        resp_q, resp_d;
  msg_s        cmd;

  logic [cce_block_width_p-1:0] mem_q [mem_els_p];

  logic [2:0]                   sz;
  logic [nb_w_lp-1:0]           nbytes;
  logic [off_w_lp-1:0]          off;
  logic [idx_w_lp-1:0]          idx;
  logic [cce_block_width_p-1:0] rd_blk, rd_shift, wr_shift;
  logic [cce_block_width_p-1:0] uc_rd_blk, merge_blk, wr_blk;
  logic                         wr_en;

  assign cmd = msg_s'(mem_io.mem_cmd_i);

  // Byte-lane view of the addressed block: sizes beyond the block clamp to it,
  // and the offset is aligned down to the access size.
  always_comb begin
    uc_rd_blk = '0;
    merge_blk = '0;
    sz        = (cmd.hdr.size > 3'(off_w_lp)) ? 3'(off_w_lp) : cmd.hdr.size;
    nbytes    = nb_w_lp'(1) << sz;
    off       = cmd.hdr.addr[off_w_lp-1:0] & ~off_w_lp'(nbytes - nb_w_lp'(1));
    idx       = cmd.hdr.addr[off_w_lp +: idx_w_lp];
    rd_blk    = mem_q[idx];
    rd_shift  = rd_blk >> {off, 3'b000};
    wr_shift  = cmd.data << {off, 3'b000};
    for (int b = 0; b < block_bytes_lp; b++) begin
      uc_rd_blk[8*b +: 8] = (b < int'(nbytes)) ? rd_shift[8*b +: 8] : 8'h00;
      merge_blk[8*b +: 8] = ((b >= int'(off)) && (b < int'(off) + int'(nbytes)))
                          ? wr_shift[8*b +: 8] : rd_blk[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    wr_en   = 1'b0;
    wr_blk  = '0;
    unique case (state_q)
      e_reset: state_d = e_ready;
      e_ready: begin
        if (mem_io.mem_cmd_v_i) begin
          resp_d.hdr  = cmd.hdr;
          resp_d.data = '0;
          // Reads sample the store before this edge's write, so responses
          // always reflect strict command order.
          unique case (cmd.hdr.msg_type)
            e_cce_mem_rd:    resp_d.data = rd_blk;
            e_cce_mem_uc_rd: resp_d.data = uc_rd_blk;
            e_cce_mem_wr: begin
              wr_en  = 1'b1;
              wr_blk = cmd.data;
            end
            e_cce_mem_uc_wr: begin
              wr_en  = 1'b1;
              wr_blk = merge_blk;
            end
            default: ;
          endcase
          cnt_d   = 8'(latency_p - 1);
          state_d = (latency_p == 1) ? e_resp : e_wait;
        end
      end
      e_wait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = e_resp;
      end
      e_resp: begin
        if (mem_io.mem_resp_yumi_i) state_d = e_ready;
      end
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < mem_els_p; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= wr_blk;
    end
  end

  assign mem_io.mem_cmd_ready_o = (state_q == e_ready);
  assign mem_io.mem_resp_v_o    = (state_q == e_resp);
  assign mem_io.mem_resp_o      = resp_q;

  // Consuming a response that is not being offered is a CCE protocol error.
  always @(posedge clk_i) begin
    if (!reset_i && mem_io.mem_resp_yumi_i)
      assert (state_q == e_resp) else $error("mem_resp_yumi_i without mem_resp_v_o");
  end

endmodule
